count_cycle_tagger: RTL and testbench

COUNT_CYCLE_TAGGER -- requirements
Module: count_cycle_tagger

---
 rtl/count_cycle_pkg.sv | 12 +
 rtl/count_tag_fifo.sv | 45 ++++
 rtl/count_cycle_tagger.sv | 115 +++++++++++
 tb/tb_count_cycle_tagger.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_cycle_pkg.sv
// Shared encodings and pipeline constants for the count/cycle tagger.
package count_cycle_pkg;

  typedef enum logic {
    MODE_DOWN = 1'b0,
    MODE_UP   = 1'b1
  } cnt_mode_e;

  localparam int PIPE_LAT  = 2;
  localparam int AF_MARGIN = 3;

endpackage

// File: rtl/count_tag_fifo.sv
// Output FIFO for tagged beats; almost_full leaves room for the beats still in the input pipeline.
module count_tag_fifo
  import count_cycle_pkg::*;
#(
  parameter int WIDTH      = 49,
  parameter int ADDR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_almost_full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic [ADDR_WIDTH:0] w_level;

  assign w_level       = r_wr_ptr - r_rd_ptr;
  assign o_empty       = (w_level == '0);
  assign o_almost_full = (w_level >= AF_LEVEL);
  assign o_rd_data     = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_rd_en && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/count_cycle_tagger.sv
// Tags each accepted stream beat with a frame-relative up/down count and a last flag,
// then buffers it through a short register pipeline into an output FIFO.
module count_cycle_tagger
  import count_cycle_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int CNT_WIDTH       = 16,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  input  logic [CNT_WIDTH-1:0]  cnt_limit,
  input  logic                  cnt_mode,
  input  logic                  frame_restart,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  m_axis_count,
  output logic [15:0]           frame_num
);

  localparam int TAG_W = DATA_WIDTH + CNT_WIDTH + 1;

  logic                 w_take;
  logic                 w_first;
  logic                 w_final;
  logic                 w_af;
  logic                 w_empty;
  logic                 w_rd_last;
  logic [CNT_WIDTH-1:0] w_count;
  logic [CNT_WIDTH-1:0] w_limit;
  cnt_mode_e            w_mode;
  logic [TAG_W-1:0]     w_rd_data;

  logic                 r_first;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_limit;
  cnt_mode_e            r_mode;
  logic [15:0]          r_frame_num;
  logic [PIPE_LAT-1:0]  r_pv;
  logic [TAG_W-1:0]     r_pd [PIPE_LAT];

  assign s_axis_tready = async_reset_n & ~w_af;
  assign w_take        = s_axis_tvalid & s_axis_tready;
  assign w_first       = r_first | frame_restart;

  // A first beat uses the live limit/mode, which are latched with it; later beats use the latched copy.
  always_comb begin
    w_limit = r_limit;
    w_mode  = r_mode;
    w_count = r_cnt;
    if (w_first) begin
      w_limit = cnt_limit;
      w_mode  = cnt_mode_e'(cnt_mode);
      w_count = (w_mode == MODE_UP) ? '0 : cnt_limit;
    end else if (r_mode == MODE_UP) begin
      w_count = r_cnt + 1'b1;
    end else begin
      w_count = r_cnt - 1'b1;
    end
    w_final = (w_mode == MODE_UP) ? (w_count == w_limit) : (w_count == '0);
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_first     <= 1'b1;
      r_cnt       <= '0;
      r_limit     <= '0;
      r_mode      <= MODE_DOWN;
      r_frame_num <= '0;
    end else if (w_take) begin
      r_cnt   <= w_count;
      r_limit <= w_limit;
      r_mode  <= w_mode;
      r_first <= w_final;
      if (w_final) r_frame_num <= r_frame_num + 1'b1;
    end else if (frame_restart) begin
      r_first <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) r_pv <= '0;
    else                r_pv <= {r_pv[PIPE_LAT-2:0], w_take};
  end

  always_ff @(posedge clk) begin
    r_pd[0] <= {w_final, w_count, s_axis_tdata};
    for (int i = 1; i < PIPE_LAT; i++) r_pd[i] <= r_pd[i-1];
  end

  count_tag_fifo #(
    .WIDTH      (TAG_W),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .i_wr_en       (r_pv[PIPE_LAT-1]),
    .i_wr_data     (r_pd[PIPE_LAT-1]),
    .i_rd_en       (m_axis_tready),
    .o_rd_data     (w_rd_data),
    .o_empty       (w_empty),
    .o_almost_full (w_af)
  );

  assign {w_rd_last, m_axis_count, m_axis_tdata} = w_rd_data;
  assign m_axis_tvalid = ~w_empty;
  assign m_axis_tlast  = w_rd_last & m_axis_tvalid;
  assign frame_num     = r_frame_num;

endmodule

// File: tb/tb_count_cycle_tagger.sv
// Directed bench for count_cycle_tagger: hand-computed count/tlast sequences per scenario.
module tb_count_cycle_tagger;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          async_reset_n;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic          s_tready;
  logic [CW-1:0] cnt_limit;
  logic          cnt_mode;
  logic          frame_restart;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tready;
  logic          m_tlast;
  logic [CW-1:0] m_count;
  logic [15:0]   frame_num;

  int total = 0;
  int bad   = 0;
  int seq   = 0;
  int n_taken = 0;

  logic [DW-1:0] cap_d [$];
  logic [CW-1:0] cap_c [$];
  logic          cap_l [$];
  int            exp_c [$];
  int            exp_l [$];

  always #5 clk = ~clk;

  count_cycle_tagger #(
    .DATA_WIDTH      (DW),
    .CNT_WIDTH       (CW),
    .FIFO_ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tready (s_tready),
    .cnt_limit     (cnt_limit),
    .cnt_mode      (cnt_mode),
    .frame_restart (frame_restart),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_count  (m_count),
    .frame_num     (frame_num)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor: records handshakes and checks that a stalled beat holds steady.
  initial begin : mon
    logic          sv;
    logic [63:0]   snap;
    sv   = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!async_reset_n) begin
        sv = 1'b0;
      end else begin
        if (sv) begin
          chk("hold_valid", 64'(m_tvalid), 64'd1);
          chk("hold_beat", 64'({m_tlast, m_count, m_tdata}), snap);
        end
        if (m_tvalid && m_tready) begin
          cap_d.push_back(m_tdata);
          cap_c.push_back(m_count);
          cap_l.push_back(m_tlast);
        end
        sv   = m_tvalid && !m_tready;
        snap = 64'({m_tlast, m_count, m_tdata});
      end
    end
  end

  task automatic cyc();
    logic took;
    @(negedge clk);
    took = s_tvalid && s_tready;
    @(posedge clk);
    #1;
    if (took) begin
      seq++;
      n_taken++;
    end
    s_tdata = DW'(seq);
  endtask

  task automatic send(input int n);
    int start;
    int budget;
    start  = n_taken;
    budget = 200;
    s_tvalid = 1'b1;
    while ((n_taken - start) < n && budget > 0) begin
      cyc();
      budget--;
    end
    s_tvalid = 1'b0;
    chk("send_taken", 64'(n_taken - start), 64'(n));
  endtask

  task automatic wait_beats(input int k);
    int budget;
    budget = 100;
    while (cap_c.size() < k && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("beat_count", 64'(cap_c.size()), 64'(k));
  endtask

  task automatic check_beats(input string tag, input int base);
    for (int i = 0; i < exp_c.size(); i++) begin
      if (i < cap_c.size()) begin
        chk($sformatf("%s_cnt%0d", tag, i), 64'(cap_c[i]), 64'(exp_c[i]));
        chk($sformatf("%s_last%0d", tag, i), 64'(cap_l[i]), 64'(exp_l[i]));
        chk($sformatf("%s_data%0d", tag, i), 64'(cap_d[i]), 64'(base + i));
      end
    end
    cap_d.delete();
    cap_c.delete();
    cap_l.delete();
  endtask

  initial begin : stim
    int base;
    int t0;
    async_reset_n = 1'b0;
    s_tvalid      = 1'b0;
    s_tdata       = '0;
    cnt_limit     = 16'd3;
    cnt_mode      = 1'b0;
    frame_restart = 1'b0;
    m_tready      = 1'b1;

    #12;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_frame_num", 64'(frame_num), 64'd0);
    #10;
    async_reset_n = 1'b1;
    #1;
    chk("rel_s_tready", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;

    // Down, limit 3, with first-beat latency probe
    base = seq;
    t0   = n_taken;
    s_tvalid = 1'b1;
    cyc();
    s_tvalid = 1'b0;
    chk("lat_take", 64'(n_taken - t0), 64'd1);
    @(negedge clk);
    chk("lat_c1", 64'(m_tvalid), 64'd0);
    @(negedge clk);
    chk("lat_c2", 64'(m_tvalid), 64'd0);
    @(negedge clk);
    chk("lat_c3", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #1;
    send(7);
    wait_beats(8);
    exp_c = '{3, 2, 1, 0, 3, 2, 1, 0};
    exp_l = '{0, 0, 0, 1, 0, 0, 0, 1};
    check_beats("down3", base);
    chk("fn_down3", 64'(frame_num), 64'd2);

    // Up, limit 4, limit changed to 1 mid-frame
    cnt_mode  = 1'b1;
    cnt_limit = 16'd4;
    base = seq;
    send(3);
    cnt_limit = 16'd1;
    send(6);
    wait_beats(9);
    exp_c = '{0, 1, 2, 3, 4, 0, 1, 0, 1};
    exp_l = '{0, 0, 0, 0, 1, 0, 1, 0, 1};
    check_beats("up4", base);
    chk("fn_up4", 64'(frame_num), 64'd5);

    // Limit 0 in both modes
    cnt_limit = 16'd0;
    cnt_mode  = 1'b0;
    base = seq;
    send(3);
    cnt_mode = 1'b1;
    send(2);
    wait_beats(5);
    exp_c = '{0, 0, 0, 0, 0};
    exp_l = '{1, 1, 1, 1, 1};
    check_beats("lim0", base);
    chk("fn_lim0", 64'(frame_num), 64'd10);

    // Restart coincident with take at count 5
    cnt_mode  = 1'b0;
    cnt_limit = 16'd9;
    base = seq;
    send(4);
    cnt_limit     = 16'd2;
    frame_restart = 1'b1;
    s_tvalid      = 1'b1;
    t0 = n_taken;
    cyc();
    frame_restart = 1'b0;
    s_tvalid      = 1'b0;
    chk("rs_take", 64'(n_taken - t0), 64'd1);
    send(2);
    wait_beats(7);
    exp_c = '{9, 8, 7, 6, 2, 1, 0};
    exp_l = '{0, 0, 0, 0, 0, 0, 1};
    check_beats("rs_take", base);
    chk("fn_rs_take", 64'(frame_num), 64'd11);

    // Restart in an idle cycle
    cnt_limit = 16'd3;
    base = seq;
    send(2);
    frame_restart = 1'b1;
    cyc();
    frame_restart = 1'b0;
    cnt_limit = 16'd1;
    send(2);
    wait_beats(4);
    exp_c = '{3, 2, 1, 0};
    exp_l = '{0, 0, 0, 1};
    check_beats("rs_idle", base);
    chk("fn_rs_idle", 64'(frame_num), 64'd12);

    // Output stalled 20 cycles under continuous input: ready drops at occupancy 5
    cnt_limit = 16'd3;
    m_tready  = 1'b0;
    base = seq;
    t0   = n_taken;
    s_tvalid = 1'b1;
    repeat (20) cyc();
    s_tvalid = 1'b0;
    chk("af_taken", 64'(n_taken - t0), 64'd7);
    chk("af_s_tready", 64'(s_tready), 64'd0);
    chk("af_m_tvalid", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    wait_beats(7);
    exp_c = '{3, 2, 1, 0, 3, 2, 1};
    exp_l = '{0, 0, 0, 1, 0, 0, 0};
    check_beats("af", base);
    chk("fn_af", 64'(frame_num), 64'd13);
    chk("af_ready_back", 64'(s_tready), 64'd1);

    // Reset mid-frame with 4 beats buffered
    m_tready = 1'b0;
    send(4);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_fn", 64'(frame_num), 64'd14);
    chk("pre_rst_m_tvalid", 64'(m_tvalid), 64'd1);
    #2;
    async_reset_n = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("mid_rst_fn", 64'(frame_num), 64'd0);
    chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
    #10;
    async_reset_n = 1'b1;
    cnt_limit = 16'd6;
    m_tready  = 1'b1;
    @(posedge clk);
    #1;
    base = seq;
    send(1);
    wait_beats(1);
    exp_c = '{6};
    exp_l = '{0};
    check_beats("post_rst", base);
    chk("fn_post_rst", 64'(frame_num), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
